// File: rtl/sixteen_seg_pkg.sv
// rtl/sixteen_seg_pkg.sv - segment bit indices, pattern type and ASCII font for the 16-segment display
package sixteen_seg_pkg;

  typedef logic [15:0] seg_t;

  localparam int SEG_A1 = 0;
  localparam int SEG_A2 = 1;
  localparam int SEG_B  = 2;
  localparam int SEG_C  = 3;
  localparam int SEG_D2 = 4;
  localparam int SEG_D1 = 5;
  localparam int SEG_E  = 6;
  localparam int SEG_F  = 7;
  localparam int SEG_G1 = 8;
  localparam int SEG_G2 = 9;
  localparam int SEG_H  = 10;
  localparam int SEG_I  = 11;
  localparam int SEG_J  = 12;
  localparam int SEG_K  = 13;
  localparam int SEG_L  = 14;
  localparam int SEG_M  = 15;

  localparam logic [7:0] DEFAULT_BLANK_CHAR = 8'h20;

  // Lowercase letters share the uppercase glyphs; everything unlisted stays dark.
  function automatic seg_t font(input logic [7:0] ch);
    logic [7:0] up;
    up = (ch >= 8'h61 && ch <= 8'h7A) ? ch - 8'h20 : ch;
    case (up)
      8'h20: font = 16'h0000;
      "A":   font = 16'h03CF;
      "B":   font = 16'h4A3F;
      "C":   font = 16'h00F3;
      "D":   font = 16'h483F;
      "E":   font = 16'h03F3;
      "F":   font = 16'h01C3;
      "G":   font = 16'h02FB;
      "H":   font = 16'h03CC;
      "I":   font = 16'h4833;
      "J":   font = 16'h007C;
      "K":   font = 16'h91C0;
      "L":   font = 16'h00F0;
      "M":   font = 16'h14CC;
      "N":   font = 16'h84CC;
      "O":   font = 16'h00FF;
      "P":   font = 16'h03C7;
      "Q":   font = 16'h80FF;
      "R":   font = 16'h83C7;
      "S":   font = 16'h03BB;
      "T":   font = 16'h4803;
      "U":   font = 16'h00FC;
      "V":   font = 16'h30C0;
      "W":   font = 16'hA0CC;
      "X":   font = 16'hB400;
      "Y":   font = 16'h5400;
      "Z":   font = 16'h3033;
      "0":   font = 16'h30FF;
      "1":   font = 16'h000C;
      "2":   font = 16'h0377;
      "3":   font = 16'h023F;
      "4":   font = 16'h038C;
      "5":   font = 16'h03BB;
      "6":   font = 16'h03FB;
      "7":   font = 16'h000F;
      "8":   font = 16'h03FF;
      "9":   font = 16'h03BF;
      "!":   font = 16'h0800;
      "\"":  font = 16'h0880;
      "-":   font = 16'h0300;
      "_":   font = 16'h0030;
      "+":   font = 16'h4B00;
      "*":   font = 16'hFF00;
      "/":   font = 16'h3000;
      "\\":  font = 16'h8400;
      "=":   font = 16'h0330;
      "?":   font = 16'h4207;
      "'":   font = 16'h1000;
      "(":   font = 16'h9000;
      ")":   font = 16'h2400;
      "<":   font = 16'h9100;
      ">":   font = 16'h2600;
      "$":   font = 16'h4BBB;
      ".":   font = 16'h0020;
      default: font = 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/sixteen_seg_font_rom.sv
// rtl/sixteen_seg_font_rom.sv - combinational ASCII to 16-segment pattern decoder
module sixteen_seg_font_rom
  import sixteen_seg_pkg::*;
(
  input  logic [7:0] char_code,
  output seg_t       pattern
);

  assign pattern = font(char_code);

endmodule

// File: rtl/sixteen_segment_display.sv
// rtl/sixteen_segment_display.sv - 8-slot character store with write-through registered segment output
module sixteen_segment_display
  import sixteen_seg_pkg::*;
#(
  parameter int         NUM_DIGITS = 8,
  parameter logic [7:0] BLANK_CHAR = DEFAULT_BLANK_CHAR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  char_in,
  input  logic        load,
  input  logic [2:0]  digit_sel,
  output logic [15:0] segments
);

  logic [7:0] char_buf [NUM_DIGITS];
  logic       sel_valid;
  logic [7:0] display_char;
  seg_t       font_pattern;
  seg_t       next_segments;

  assign sel_valid = int'(digit_sel) < NUM_DIGITS;

  // A loading character is shown on the same edge it is stored.
  assign display_char = load ? char_in : (sel_valid ? char_buf[digit_sel] : BLANK_CHAR);

  sixteen_seg_font_rom u_font_rom (
    .char_code (display_char),
    .pattern   (font_pattern)
  );

  assign next_segments = (load || sel_valid) ? font_pattern : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        char_buf[i] <= BLANK_CHAR;
      end
    end else if (load && sel_valid) begin
      char_buf[digit_sel] <= char_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      segments <= '0;
    end else begin
      segments <= next_segments;
    end
  end

endmodule

// File: tb/tb_sixteen_segment_display.sv
// tb/tb_sixteen_segment_display.sv - self-checking bench for sixteen_segment_display
module tb_sixteen_segment_display;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  char_in;
  logic        load;
  logic [2:0]  digit_sel;
  logic [15:0] segments;

  int tests_run = 0;
  int tests_failed = 0;

  logic [15:0] ftab [128];
  logic [7:0]  mbuf [8];

  sixteen_segment_display dut (
    .clk       (clk),
    .rst       (rst),
    .char_in   (char_in),
    .load      (load),
    .digit_sel (digit_sel),
    .segments  (segments)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_font(input logic [7:0] c);
    int code;
    code = int'(c);
    if (code >= 97 && code <= 122) code = code - 32;
    if (code >= 128) return 16'h0000;
    return ftab[code];
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mbuf[i] = 8'h20;
  endtask

  // Drive one cycle, advance the reference model, and compare just after the edge.
  task automatic cycle(input logic ld, input logic [2:0] sel, input logic [7:0] ch, input string tag);
    logic [15:0] exp;
    load = ld;
    digit_sel = sel;
    char_in = ch;
    exp = ld ? ref_font(ch) : ref_font(mbuf[sel]);
    if (ld) mbuf[sel] = ch;
    @(posedge clk);
    #1;
    check(tag, segments, exp);
  endtask

  initial begin
    logic [7:0]  hello [6];
    logic [15:0] hello_seg [8];

    for (int i = 0; i < 128; i++) ftab[i] = 16'h0000;
    ftab["A"] = 16'h03CF; ftab["B"] = 16'h4A3F; ftab["C"] = 16'h00F3; ftab["D"] = 16'h483F;
    ftab["E"] = 16'h03F3; ftab["F"] = 16'h01C3; ftab["G"] = 16'h02FB; ftab["H"] = 16'h03CC;
    ftab["I"] = 16'h4833; ftab["J"] = 16'h007C; ftab["K"] = 16'h91C0; ftab["L"] = 16'h00F0;
    ftab["M"] = 16'h14CC; ftab["N"] = 16'h84CC; ftab["O"] = 16'h00FF; ftab["P"] = 16'h03C7;
    ftab["Q"] = 16'h80FF; ftab["R"] = 16'h83C7; ftab["S"] = 16'h03BB; ftab["T"] = 16'h4803;
    ftab["U"] = 16'h00FC; ftab["V"] = 16'h30C0; ftab["W"] = 16'hA0CC; ftab["X"] = 16'hB400;
    ftab["Y"] = 16'h5400; ftab["Z"] = 16'h3033;
    ftab["0"] = 16'h30FF; ftab["1"] = 16'h000C; ftab["2"] = 16'h0377; ftab["3"] = 16'h023F;
    ftab["4"] = 16'h038C; ftab["5"] = 16'h03BB; ftab["6"] = 16'h03FB; ftab["7"] = 16'h000F;
    ftab["8"] = 16'h03FF; ftab["9"] = 16'h03BF;
    ftab["!"] = 16'h0800; ftab["\""] = 16'h0880; ftab["-"] = 16'h0300; ftab["_"] = 16'h0030;
    ftab["+"] = 16'h4B00; ftab["*"] = 16'hFF00; ftab["/"] = 16'h3000; ftab["\\"] = 16'h8400;
    ftab["="] = 16'h0330; ftab["?"] = 16'h4207; ftab["'"] = 16'h1000; ftab["("] = 16'h9000;
    ftab[")"] = 16'h2400; ftab["<"] = 16'h9100; ftab[">"] = 16'h2600; ftab["$"] = 16'h4BBB;
    ftab["."] = 16'h0020;

    hello[0] = "H"; hello[1] = "E"; hello[2] = "L"; hello[3] = "L"; hello[4] = "O"; hello[5] = "!";
    hello_seg[0] = 16'h03CC; hello_seg[1] = 16'h03F3; hello_seg[2] = 16'h00F0; hello_seg[3] = 16'h00F0;
    hello_seg[4] = 16'h00FF; hello_seg[5] = 16'h0800; hello_seg[6] = 16'h0000; hello_seg[7] = 16'h0000;

    rst = 1'b1;
    load = 1'b0;
    digit_sel = 3'd0;
    char_in = 8'h41;
    model_reset();
    #1;
    check("reset_async", segments, 16'h0000);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check("reset_hold", segments, 16'h0000);
    end
    rst = 1'b0;

    for (int i = 0; i < 8; i++) cycle(1'b0, 3'(i), 8'h00, "blank_sweep");

    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 3'(i), hello[i], "hello_load_model");
      check("hello_load_const", segments, hello_seg[i]);
    end
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 3'(i), 8'hFF, "hello_read_model");
      check("hello_read_const", segments, hello_seg[i]);
    end

    cycle(1'b1, 3'd6, "h", "lower_h");
    check("lower_h_const", segments, 16'h03CC);
    cycle(1'b1, 3'd7, 8'h07, "ctrl_code");
    check("ctrl_code_const", segments, 16'h0000);
    cycle(1'b1, 3'd7, "1", "digit_1");
    check("digit_1_const", segments, 16'h000C);
    cycle(1'b1, 3'd7, "0", "digit_0");
    check("digit_0_const", segments, 16'h30FF);
    cycle(1'b0, 3'd6, 8'h00, "slot6_read");
    check("slot6_read_const", segments, 16'h03CC);

    #3;
    rst = 1'b1;
    #1;
    check("midrun_reset_async", segments, 16'h0000);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 3'(i), 8'h00, "post_reset_model");
      check("post_reset_const", segments, 16'h0000);
    end

    for (int i = 0; i < 8; i++) cycle(1'b1, 3'(i), 8'(32 + $urandom_range(0, 94)), "prefill");
    cycle(1'b1, 3'd2, "E", "hold_e");
    cycle(1'b1, 3'd2, "L", "hold_l");
    cycle(1'b1, 3'd2, "O", "hold_o");
    cycle(1'b0, 3'd2, 8'h00, "hold_slot2");
    check("hold_slot2_const", segments, 16'h00FF);
    for (int i = 0; i < 8; i++) cycle(1'b0, 3'(i), 8'h00, "hold_others");

    for (int c = 0; c < 256; c++) cycle(1'b1, 3'($urandom_range(0, 7)), 8'(c), "font_sweep");

    for (int n = 0; n < 400; n++) begin
      cycle(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)), "random");
    end

    load = 1'b0;
    digit_sel = 3'bxxx;
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) cycle(1'b0, 3'(i), 8'h00, "x_sel_no_corrupt");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sixteen_segment_display.md
Name: sixteen_segment_display

Overview:
8-digit character store with an ASCII-to-16-segment decoder, for alphanumeric front-panel displays. The host writes one ASCII character at a time into a digit slot chosen by digit_sel. The block continuously outputs the registered segment pattern of the slot currently addressed by digit_sel. The external digit-scan/multiplex logic lives outside this block.

Parameters:
NUM_DIGITS, 8, number of character slots; must be ≤ 2**3 to match digit_sel width.
BLANK_CHAR, 8'h20, character loaded into every slot on reset.

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  asynchronous, active-high reset.
char_in  input  8  ASCII character to store.
load  input  1  write strobe; sampled on rising clk.
digit_sel  input  3  slot address, used for both write and display.
segments  output  16  active-high segment drive (1 = lit), registered.

Behaviour:
- Segment bit map: 0 a1, 1 a2, 2 b, 3 c, 4 d2, 5 d1, 6 e, 7 f, 8 g1, 9 g2, 10 h (UL diagonal), 11 i (top centre), 12 j (UR diagonal), 13 k (LL diagonal), 14 l (bottom centre), 15 m (LR diagonal).
- Reset (async assert, sync release): all slots = BLANK_CHAR; segments = 16'h0000.
- Write: on a rising edge with load=1 and digit_sel < NUM_DIGITS, buf[digit_sel] <= char_in.
- Writes with digit_sel ≥ NUM_DIGITS are ignored. They are only possible when NUM_DIGITS < 8.
- Display: every rising edge, segments <= font(load ? char_in : buf[digit_sel]). This write-through gives the new pattern on the same edge as the load.
- Latency: one clock from a change of digit_sel or char_in to segments.
- If digit_sel ≥ NUM_DIGITS and load = 0, segments <= 0.
- load held high for N cycles performs N writes, last value wins. No handshake, no busy state.
- Font (combinational, pure function):
  - Space → 0x0000.
  - 'H' → 0x03CC.
  - 'E' → 0x03F3.
  - 'L' → 0x00F0.
  - 'O' → 0x00FF.
  - '!' → 0x0800.
  - '0' → 0x30FF.
  - '1' → 0x000C.
  - Other 'A'–'Z', '0'–'9' and punctuation " - _ + * / \ = ? ' ( ) < > $ ." come from the package font table, which is the golden reference.
- Lowercase 'a'–'z' map to their uppercase patterns.
- Any code not in the table, including ≥ 0x80 and control codes, → 0x0000.
- Reset asserted mid-operation: buffer and segments clear immediately, regardless of clk.
- X on digit_sel while load = 0 must not corrupt the buffer.

Decomposition:
- Package sixteen_seg_pkg holds:
  - the SEG_* bit-index constants;
  - the typedef seg_t (logic [15:0]);
  - the font lookup function or constant table with all character codes;
  - the BLANK_CHAR default.
- One sub-module, sixteen_seg_font_rom: a purely combinational 8-bit ASCII → 16-bit pattern decoder.
- Top level holds only the buffer, the write-through mux and the output register.

Test Plan:
- Reset: assert rst for 2 cycles, then sweep digit_sel 0..7 with load=0 → segments 0x0000 in reset and 0x0000 (blank) on every slot after release.
- Write "HELLO!" into slots 0..5, one-cycle load pulse each → on each load edge segments = 0x03CC, 0x03F3, 0x00F0, 0x00F0, 0x00FF, 0x0800 respectively.
- Readback: after the writes, step digit_sel 0..7 → 0x03CC, 0x03F3, 0x00F0, 0x00F0, 0x00FF, 0x0800, 0x0000, 0x0000, each one cycle after the address changes.
- Case folding and unknown codes: load 'h' to slot 6 → 0x03CC; load 8'h07 to slot 7 → 0x0000; load '1' then '0' to slot 7 → 0x000C, then 0x30FF.
- Async reset mid-run: assert rst between clock edges after the writes → segments 0 immediately; after release, every slot reads 0x0000.
- load held 3 cycles with char_in 'E','L','O' on slot 2 → slot 2 ends at 0x00FF; the other slots are unchanged.
